// File: rtl/gin_vector_fetcher.sv
// Strided BRAM-to-GIN vector staging engine.
// Each command fetches cmd_count vectors of LANES elements from a 1-cycle-latency BRAM.
// Padded lanes are zero-filled without a read. Each packed vector is offered on GIN
// with an enable/ready handshake. The fetch of the next vector overlaps the handshake
// of the current one, using an assembly register and an output register.
module gin_vector_fetcher #(
  parameter int unsigned ADDRESS_BITWIDTH = 32,
  parameter int unsigned DATA_BITWIDTH    = 32,
  parameter int unsigned ELEM_W           = 8,
  parameter int unsigned LANES            = 4,
  parameter int unsigned CNT_W            = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [ADDRESS_BITWIDTH-1:0] cmd_addr,
  input  logic [ADDRESS_BITWIDTH-1:0] cmd_stride,
  input  logic [CNT_W-1:0]            cmd_count,
  input  logic [LANES-1:0]            cmd_pad,
  input  logic                        flush,
  output logic [ADDRESS_BITWIDTH-1:0] bram_address,
  output logic                        bram_e,
  input  logic [DATA_BITWIDTH-1:0]    bram_rdata,
  output logic                        gin_enable,
  input  logic                        gin_ready,
  output logic [ELEM_W*LANES-1:0]     gin_value,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned VW = ELEM_W * LANES;
  // lane_q counts 0..LANES; the value LANES is the capture-only cycle of the last lane.
  localparam int unsigned LW = $clog2(LANES + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic [ADDRESS_BITWIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_BITWIDTH-1:0] stride_q, stride_d;
  logic [LANES-1:0]            pad_q, pad_d;
  logic [CNT_W-1:0]            vec_left_q, vec_left_d;
  logic [LW-1:0]               lane_q, lane_d;
  logic [VW-1:0]               asm_q, asm_d;
  logic [VW-1:0]               out_q, out_d;
  logic                        out_full_q, out_full_d;

  logic          issue, cap, last_lane, out_free, xfer, load, accept;
  logic          lane_pad, cap_pad;
  logic [LW-1:0] cap_idx;
  logic [VW-1:0] asm_merged;

  assign issue     = (state_q == StFetch) && (lane_q != LW'(LANES));
  // Data for lane lane_q-1 arrives in the cycle after its issue.
  assign cap       = (state_q == StFetch) && (lane_q != '0);
  assign cap_idx   = lane_q - LW'(1);
  assign last_lane = (state_q == StFetch) && (lane_q == LW'(LANES));
  assign out_free  = !out_full_q || gin_ready;
  assign xfer      = out_full_q && gin_ready;
  assign load      = (last_lane || (state_q == StHold)) && out_free;
  assign accept    = cmd_valid && cmd_ready;

  assign cmd_ready    = (state_q == StIdle) && !out_full_q;
  assign busy         = !cmd_ready;
  assign bram_address = addr_q;
  assign bram_e       = issue && !lane_pad;
  assign gin_enable   = out_full_q;
  assign gin_value    = out_q;
  // In DRAIN the output register holds only the final vector, or nothing for count 0.
  assign done         = (state_q == StDrain) && out_free && !flush;

  // Look up the pad bit of the issuing lane and of the capturing lane.
  always_comb begin
    lane_pad = 1'b0;
    cap_pad  = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_q == LW'(l)) lane_pad = pad_q[l];
      if (cap_idx == LW'(l)) cap_pad = pad_q[l];
    end
  end

  // Merge the element arriving this cycle into the assembly vector.
  always_comb begin
    asm_merged = asm_q;
    for (int l = 0; l < LANES; l++) begin
      if (cap_idx == LW'(l)) begin
        asm_merged[l*ELEM_W +: ELEM_W] = cap_pad ? '0 : bram_rdata[ELEM_W-1:0];
      end
    end
  end

  // Next-state logic for the FSM, the address accumulator and both vector registers.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    pad_d      = pad_q;
    vec_left_d = vec_left_q;
    lane_d     = lane_q;
    asm_d      = asm_q;
    out_d      = out_q;
    out_full_d = out_full_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d     = cmd_addr;
          stride_d   = cmd_stride;
          pad_d      = cmd_pad;
          vec_left_d = cmd_count;
          lane_d     = '0;
          state_d    = (cmd_count == '0) ? StDrain : StFetch;
        end
      end
      StFetch: begin
        if (issue) begin
          addr_d = addr_q + stride_q;
          lane_d = lane_q + LW'(1);
        end
        if (cap) asm_d = asm_merged;
        if (last_lane) begin
          if (out_free) begin
            vec_left_d = vec_left_q - CNT_W'(1);
            lane_d     = '0;
            state_d    = (vec_left_q == CNT_W'(1)) ? StDrain : StFetch;
          end else begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (out_free) begin
          vec_left_d = vec_left_q - CNT_W'(1);
          lane_d     = '0;
          state_d    = (vec_left_q == CNT_W'(1)) ? StDrain : StFetch;
        end
      end
      StDrain: begin
        if (out_free) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      out_d      = (state_q == StHold) ? asm_q : asm_merged;
      out_full_d = 1'b1;
    end else if (xfer) begin
      out_full_d = 1'b0;
    end

    // Abort wins over everything, including a simultaneous accept.
    if (flush) begin
      state_d    = StIdle;
      vec_left_d = '0;
      lane_d     = '0;
      asm_d      = '0;
      out_d      = '0;
      out_full_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      stride_q   <= '0;
      pad_q      <= '0;
      vec_left_q <= '0;
      lane_q     <= '0;
      asm_q      <= '0;
      out_q      <= '0;
      out_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      pad_q      <= pad_d;
      vec_left_q <= vec_left_d;
      lane_q     <= lane_d;
      asm_q      <= asm_d;
      out_q      <= out_d;
      out_full_q <= out_full_d;
    end
  end

endmodule

// File: tb/tb_gin_vector_fetcher.sv
// Directed bench for gin_vector_fetcher (LANES=4, ELEM_W=8).
// The memory holds m[a] = a[7:0] ^ 8'hA5, with junk in the upper bits of the data word.
module tb_gin_vector_fetcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_stride = '0;
  logic [7:0]  cmd_count = '0;
  logic [3:0]  cmd_pad = '0;
  logic        flush = 1'b0;
  logic [31:0] bram_address;
  logic        bram_e;
  logic [31:0] bram_rdata = 32'hDEADBEEF;
  logic        gin_enable;
  logic        gin_ready = 1'b0;
  logic [31:0] gin_value;
  logic        busy;
  logic        done;

  gin_vector_fetcher #(
    .ADDRESS_BITWIDTH(32),
    .DATA_BITWIDTH   (32),
    .ELEM_W          (8),
    .LANES           (4),
    .CNT_W           (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_stride  (cmd_stride),
    .cmd_count   (cmd_count),
    .cmd_pad     (cmd_pad),
    .flush       (flush),
    .bram_address(bram_address),
    .bram_e      (bram_e),
    .bram_rdata  (bram_rdata),
    .gin_enable  (gin_enable),
    .gin_ready   (gin_ready),
    .gin_value   (gin_value),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // BRAM model: data valid the cycle after enable; junk otherwise.
  always @(posedge clk) begin
    bram_rdata <= bram_e ? {24'hC0FFEE, bram_address[7:0] ^ 8'hA5} : 32'hDEADBEEF;
  end

  int          passed = 0;
  int          total = 0;
  int          done_cnt = 0;
  logic [63:0] done_cyc = '0;
  logic [63:0] cyc = '0;
  logic [63:0] acc_cyc = '0;
  logic [63:0] addr_log[$];
  logic [63:0] val_log[$];
  logic [63:0] xfer_cyc[$];

  // Edge monitor: logs reads, transfers and done pulses with their edge index.
  always @(posedge clk) begin
    if (bram_e) addr_log.push_back(64'(bram_address));
    if (gin_enable && gin_ready) begin
      val_log.push_back(64'(gin_value));
      xfer_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    cyc = cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] qget(input logic [63:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 'x;
  endfunction

  task automatic clear_logs();
    addr_log.delete();
    val_log.delete();
    xfer_cyc.delete();
    done_cnt = 0;
  endtask

  // Present a command for one edge; returns at the negedge after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] s, input logic [7:0] n,
                       input logic [3:0] p);
    @(negedge clk);
    chk("cmd_ready before accept", 64'(cmd_ready), 64'd1);
    cmd_addr   = a;
    cmd_stride = s;
    cmd_count  = n;
    cmd_pad    = p;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    acc_cyc   = cyc - 1;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!cmd_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    logic ok;
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset outputs", {bram_e, gin_enable, done, bram_address, gin_value},
        {3'b000, 32'h0, 32'h0});
    rst = 1'b1;

    // Basic two-vector fetch with continuous ready.
    clear_logs();
    gin_ready = 1'b1;
    issue(32'h100, 32'd1, 8'd2, 4'b0000);
    wait_idle(100, "t1 completes");
    chk("t1 read count", 64'(addr_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1 addr%0d", i), qget(addr_log, i), 64'h100 + 64'(i));
    end
    chk("t1 xfer count", 64'(val_log.size()), 64'd2);
    chk("t1 vec0", qget(val_log, 0), 64'hA6A7A4A5);
    chk("t1 vec1", qget(val_log, 1), 64'hA2A3A0A1);
    chk("t1 first latency", qget(xfer_cyc, 0) - acc_cyc, 64'd6);
    chk("t1 period", qget(xfer_cyc, 1) - qget(xfer_cyc, 0), 64'd5);
    chk("t1 done count", 64'(done_cnt), 64'd1);
    chk("t1 done on last xfer", done_cyc, qget(xfer_cyc, 1));

    // Padding lanes 0 and 3 with stride 4.
    clear_logs();
    issue(32'h40, 32'd4, 8'd1, 4'b1001);
    wait_idle(100, "t2 completes");
    chk("t2 read count", 64'(addr_log.size()), 64'd2);
    chk("t2 addr0", qget(addr_log, 0), 64'h44);
    chk("t2 addr1", qget(addr_log, 1), 64'h48);
    chk("t2 vec", qget(val_log, 0), 64'h00EDE100);
    chk("t2 done count", 64'(done_cnt), 64'd1);

    // Backpressure: hold gin_ready low for a while with count=3.
    clear_logs();
    gin_ready = 1'b0;
    issue(32'h200, 32'd1, 8'd3, 4'b0000);
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gin_enable && gin_value !== 32'hA6A7A4A5) ok = 1'b0;
    end
    chk("t3 held value stable", 64'(ok), 64'd1);
    chk("t3 enable while stalled", 64'(gin_enable), 64'd1);
    chk("t3 reads while stalled", 64'(addr_log.size()), 64'd8);
    chk("t3 bram_e in hold", 64'(bram_e), 64'd0);
    gin_ready = 1'b1;
    wait_idle(100, "t3 completes");
    chk("t3 read count", 64'(addr_log.size()), 64'd12);
    chk("t3 xfer count", 64'(val_log.size()), 64'd3);
    chk("t3 vec0", qget(val_log, 0), 64'hA6A7A4A5);
    chk("t3 vec1", qget(val_log, 1), 64'hA2A3A0A1);
    chk("t3 vec2", qget(val_log, 2), 64'hAEAFACAD);
    chk("t3 done count", 64'(done_cnt), 64'd1);

    // Zero-count command.
    clear_logs();
    issue(32'h500, 32'd1, 8'd0, 4'b0000);
    chk("t4 done after accept", 64'(done), 64'd1);
    @(negedge clk);
    chk("t4 cmd_ready next", 64'(cmd_ready), 64'd1);
    chk("t4 done single", 64'(done_cnt), 64'd1);
    chk("t4 no reads", 64'(addr_log.size()), 64'd0);
    chk("t4 no xfers", 64'(val_log.size()), 64'd0);

    // Address wrap.
    clear_logs();
    issue(32'hFFFFFFFE, 32'd1, 8'd1, 4'b0000);
    wait_idle(100, "t5 completes");
    chk("t5 addr0", qget(addr_log, 0), 64'hFFFFFFFE);
    chk("t5 addr1", qget(addr_log, 1), 64'hFFFFFFFF);
    chk("t5 addr2", qget(addr_log, 2), 64'h0);
    chk("t5 addr3", qget(addr_log, 3), 64'h1);
    chk("t5 vec", qget(val_log, 0), 64'hA4A55A5B);

    // Flush in the middle of fetching vector 1 while vector 0 is held.
    clear_logs();
    gin_ready = 1'b0;
    issue(32'h300, 32'd1, 8'd2, 4'b0000);
    repeat (6) @(negedge clk);
    chk("t6 mid fetch read", 64'(bram_e), 64'd1);
    chk("t6 vec0 held", 64'(gin_enable), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t6 enable after flush", 64'(gin_enable), 64'd0);
    chk("t6 ready after flush", 64'(cmd_ready), 64'd1);
    chk("t6 bram_e after flush", 64'(bram_e), 64'd0);
    chk("t6 no done", 64'(done_cnt), 64'd0);
    gin_ready = 1'b1;
    clear_logs();
    issue(32'h100, 32'd1, 8'd1, 4'b0000);
    wait_idle(100, "t6 recovery completes");
    chk("t6 recovery xfers", 64'(val_log.size()), 64'd1);
    chk("t6 recovery vec", qget(val_log, 0), 64'hA6A7A4A5);
    chk("t6 recovery done", 64'(done_cnt), 64'd1);

    // Asynchronous reset in the middle of a command.
    clear_logs();
    gin_ready = 1'b0;
    issue(32'h300, 32'd1, 8'd2, 4'b0000);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t7 enable in reset", 64'(gin_enable), 64'd0);
    chk("t7 ready in reset", 64'(cmd_ready), 64'd1);
    chk("t7 bram_e in reset", 64'(bram_e), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    gin_ready = 1'b1;
    chk("t7 no done", 64'(done_cnt), 64'd0);
    clear_logs();
    issue(32'h40, 32'd4, 8'd1, 4'b1001);
    wait_idle(100, "t7 recovery completes");
    chk("t7 recovery vec", qget(val_log, 0), 64'h00EDE100);
    chk("t7 recovery reads", 64'(addr_log.size()), 64'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
